// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream valid/ready/data, downstream
// valid/ready/data, flush request and the stall counter.
// Modports:
//   master - the environment around the stage (drives in_*, out_ready, flush)
//   slave  - the stage itself (drives in_ready, out_*, stall_cnt)
interface pipe_skid_stage_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  stall_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_valid,
        output out_data,
        output stall_cnt
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a two-entry skid buffer, synchronous flush and
// a saturating back-pressure counter.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pipe_skid_stage_if.slave (in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data, flush, stall_cnt)
// All outputs are decodes of state or direct register values.
module pipe_skid_stage #(
    parameter int unsigned      WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_skid_stage_if.slave      bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // State and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE_VAL;
            skid_q      <= BUBBLE_VAL;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state, payload movement and stall counting
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        if (bus.flush) begin
            // Flush wins: any accepted input this cycle is dropped
            state_d     = ST_EMPTY;
            main_d      = BUBBLE_VAL;
            skid_d      = BUBBLE_VAL;
            stall_cnt_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (bus.in_valid) begin
                        main_d  = bus.in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            main_d = bus.in_data;
                        end else begin
                            main_d  = BUBBLE_VAL;
                            state_d = ST_EMPTY;
                        end
                    end else if (bus.in_valid) begin
                        // in_ready was high, so this beat must be caught
                        skid_d  = bus.in_data;
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (bus.out_ready) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase

            if ((state_q != ST_EMPTY) && !bus.out_ready && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.in_ready  = (state_q != ST_SKID);
    assign bus.out_data  = main_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage. u_a: WIDTH=64, zero bubble, CNT_W=8.
// u_b: WIDTH=16, bubble 16'hDEAD, CNT_W=4 (saturation and drain cases).
module tb_pipe_skid_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_skid_stage_if #(.WIDTH(64), .CNT_W(8)) ia ();
    pipe_skid_stage_if #(.WIDTH(16), .CNT_W(4)) ib ();

    pipe_skid_stage #(.WIDTH(64), .BUBBLE_VAL(64'h0), .CNT_W(8)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    pipe_skid_stage #(.WIDTH(16), .BUBBLE_VAL(16'hDEAD), .CNT_W(4)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ov, input logic ir,
                         input logic [63:0] od, input logic [7:0] sc);
        check({tag, ".out_valid"}, 64'(ia.out_valid), 64'(ov));
        check({tag, ".in_ready"},  64'(ia.in_ready),  64'(ir));
        check({tag, ".out_data"},  ia.out_data,       od);
        check({tag, ".stall_cnt"}, 64'(ia.stall_cnt), 64'(sc));
    endtask

    task automatic chk_b(input string tag, input logic ov, input logic ir,
                         input logic [15:0] od, input logic [3:0] sc);
        check({tag, ".out_valid"}, 64'(ib.out_valid), 64'(ov));
        check({tag, ".in_ready"},  64'(ib.in_ready),  64'(ir));
        check({tag, ".out_data"},  64'(ib.out_data),  64'(od));
        check({tag, ".stall_cnt"}, 64'(ib.stall_cnt), 64'(sc));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b0; ia.flush = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b0; ib.flush = 1'b0;

        // Reset state
        step();
        step();
        chk_a("reset_a", 1'b0, 1'b1, 64'h0, 8'd0);
        chk_b("reset_b", 1'b0, 1'b1, 16'hDEAD, 4'd0);
        rst = 1'b0;

        // Streaming 1..8 with out_ready high: 1-cycle latency, no stalls
        for (int i = 1; i <= 8; i++) begin
            ia.in_valid  = 1'b1;
            ia.in_data   = 64'(i);
            ia.out_ready = 1'b1;
            step();
            chk_a($sformatf("stream%0d", i), 1'b1, 1'b1, 64'(i), 8'd0);
        end
        ia.in_valid = 1'b0;
        step();
        chk_a("stream_drain", 1'b0, 1'b1, 64'h0, 8'd0);

        // Back-pressure: A in main, B into skid, C held upstream
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1; ia.in_data = 64'hA;
        step();
        chk_a("bp_A", 1'b1, 1'b1, 64'hA, 8'd0);
        ia.in_data = 64'hB;
        step();
        chk_a("bp_B_skid", 1'b1, 1'b0, 64'hA, 8'd1);
        ia.in_data = 64'hC;
        step();
        chk_a("bp_C_held", 1'b1, 1'b0, 64'hA, 8'd2);
        ia.out_ready = 1'b1;
        step();
        chk_a("bp_out_B", 1'b1, 1'b1, 64'hB, 8'd2);
        step();
        chk_a("bp_out_C", 1'b1, 1'b1, 64'hC, 8'd2);
        ia.in_valid = 1'b0;
        step();
        chk_a("bp_empty", 1'b0, 1'b1, 64'h0, 8'd2);

        // Flush while in SKID with an incoming payload
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1; ia.in_data = 64'hD;
        step();
        chk_a("fl_D", 1'b1, 1'b1, 64'hD, 8'd2);
        ia.in_data = 64'hE;
        step();
        chk_a("fl_skid", 1'b1, 1'b0, 64'hD, 8'd3);
        ia.flush   = 1'b1;
        ia.in_data = 64'hF;
        step();
        chk_a("fl_after", 1'b0, 1'b1, 64'h0, 8'd0);
        ia.flush     = 1'b0;
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a($sformatf("fl_quiet%0d", i), 1'b0, 1'b1, 64'h0, 8'd0);
        end

        // Asynchronous reset while in SKID
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1; ia.in_data = 64'h11;
        step();
        ia.in_data = 64'h22;
        step();
        chk_a("ar_skid", 1'b1, 1'b0, 64'h11, 8'd1);
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk_a("ar_nolck", 1'b0, 1'b1, 64'h0, 8'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a($sformatf("ar_post%0d", i), 1'b0, 1'b1, 64'h0, 8'd0);
        end

        // Saturation on CNT_W=4 instance
        ib.out_ready = 1'b0;
        ib.in_valid  = 1'b1; ib.in_data = 16'h1234;
        step();
        chk_b("sat_load", 1'b1, 1'b1, 16'h1234, 4'd0);
        ib.in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk_b($sformatf("sat%0d", i), 1'b1, 1'b1, 16'h1234, (i > 15) ? 4'd15 : 4'(i));
        end
        ib.out_ready = 1'b1;
        step();
        chk_b("sat_drain", 1'b0, 1'b1, 16'hDEAD, 4'd15);

        // Drain single payload back to bubble value
        ib.in_valid = 1'b1; ib.in_data = 16'h0042;
        step();
        chk_b("drain_full", 1'b1, 1'b1, 16'h0042, 4'd15);
        ib.in_valid = 1'b0;
        step();
        chk_b("drain_empty", 1'b0, 1'b1, 16'hDEAD, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
